// File: rtl/aux_perf_counter_bank_pkg.sv
// Shared constants for the performance-counter bank: channel assignments
// and the display-mux codes that route the bank onto the 7-segment path.
package aux_perf_counter_bank_pkg;

   typedef enum logic [2:0] {
      PERF_CH_CYC = 3'd0,
      PERF_CH_JMP = 3'd1,
      PERF_CH_BCH = 3'd2,
      PERF_CH_BED = 3'd3,
      PERF_CH_BUB = 3'd4,
      PERF_CH_LU  = 3'd5
   } perf_ch_e;

   localparam int PERF_NUM_CH = 8;

   // Display data mux codes that pick the bank's live or shadow readout.
   localparam logic [3:0] DISP_SEL_PERF_LIVE   = 4'hA;
   localparam logic [3:0] DISP_SEL_PERF_SHADOW = 4'hB;

endpackage

// File: rtl/aux_perf_counter_bank_if.sv
// Control and readout bundle between the core status logic and the counter bank.
interface aux_perf_counter_bank_if #(
   parameter int NumCh  = 8,
   parameter int CntBit = 32,
   parameter int SelBit = 5
);
   logic              en;
   logic [NumCh-1:0]  evt;
   logic              clr;
   logic              snap;
   logic [SelBit-1:0] sel;
   logic              rd_shadow;
   logic [CntBit-1:0] rd_data;
   logic [NumCh-1:0]  ovf;
   logic              snap_valid;

   modport master (
      output en, evt, clr, snap, sel, rd_shadow,
      input  rd_data, ovf, snap_valid
   );

   modport slave (
      input  en, evt, clr, snap, sel, rd_shadow,
      output rd_data, ovf, snap_valid
   );
endinterface

// File: rtl/aux_perf_counter_channel.sv
// One counter channel: live count, snapshot shadow and sticky overflow flag,
// wrapping or saturating at all-ones depending on Saturate.
module aux_perf_counter_channel
   import aux_perf_counter_bank_pkg::*;
#(
   parameter int CntBit   = 32,
   parameter int Saturate = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              clr,
   input  logic              snap,
   output logic [CntBit-1:0] live,
   output logic [CntBit-1:0] shadow,
   output logic              ovf
);

   // Shadow samples the pre-update live value, so a snap coinciding with clr keeps the old count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live   <= '0;
         shadow <= '0;
         ovf    <= 1'b0;
      end else begin
         if (snap) begin
            shadow <= live;
         end
         if (clr) begin
            live <= '0;
            ovf  <= 1'b0;
         end else if (inc) begin
            if (live == {CntBit{1'b1}}) begin
               ovf  <= 1'b1;
               live <= (Saturate != 0) ? live : '0;
            end else begin
               live <= live + CntBit'(1);
            end
         end
      end
   end

endmodule

// File: rtl/aux_perf_counter_bank.sv
// Bank of NumCh performance counters with coherent snapshot and a registered
// readout mux feeding the display data path.
module aux_perf_counter_bank
   import aux_perf_counter_bank_pkg::*;
#(
   parameter int NumCh    = PERF_NUM_CH,
   parameter int CntBit   = 32,
   parameter int SelBit   = 5,
   parameter int Saturate = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   aux_perf_counter_bank_if.slave  bus
);

   logic [CntBit-1:0] live_cnt   [NumCh];
   logic [CntBit-1:0] shadow_cnt [NumCh];
   logic [CntBit-1:0] rd_next;

   for (genvar g = 0; g < NumCh; g++) begin : g_ch
      aux_perf_counter_channel #(
         .CntBit   (CntBit),
         .Saturate (Saturate)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .inc    (bus.en & bus.evt[g]),
         .clr    (bus.clr),
         .snap   (bus.snap),
         .live   (live_cnt[g]),
         .shadow (shadow_cnt[g]),
         .ovf    (bus.ovf[g])
      );
   end

   // Unpopulated select codes fall through to zero.
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NumCh; i++) begin
         if (bus.sel == SelBit'(i)) begin
            rd_next = bus.rd_shadow ? shadow_cnt[i] : live_cnt[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_data <= '0;
      end else begin
         bus.rd_data <= rd_next;
      end
   end

   // snap outranks clr so a simultaneous snap-and-clear still reports a valid shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.snap_valid <= 1'b0;
      end else if (bus.snap) begin
         bus.snap_valid <= 1'b1;
      end else if (bus.clr) begin
         bus.snap_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aux_perf_counter_bank.sv
// Drives three bank variants (32-bit wrap, 8-bit wrap, 8-bit saturate) with the
// same stimulus and compares each against an array-based counting model.
`timescale 1ns/100ps
module tb_aux_perf_counter_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] evt;
   logic       clr;
   logic       snap;
   logic [4:0] sel;
   logic       rd_shadow;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   aux_perf_counter_bank_if #(.NumCh(8), .CntBit(32), .SelBit(5)) bus0 ();
   aux_perf_counter_bank_if #(.NumCh(8), .CntBit(8),  .SelBit(5)) bus1 ();
   aux_perf_counter_bank_if #(.NumCh(8), .CntBit(8),  .SelBit(5)) bus2 ();

   assign bus0.en = en;  assign bus0.evt = evt;  assign bus0.clr = clr;
   assign bus0.snap = snap;  assign bus0.sel = sel;  assign bus0.rd_shadow = rd_shadow;
   assign bus1.en = en;  assign bus1.evt = evt;  assign bus1.clr = clr;
   assign bus1.snap = snap;  assign bus1.sel = sel;  assign bus1.rd_shadow = rd_shadow;
   assign bus2.en = en;  assign bus2.evt = evt;  assign bus2.clr = clr;
   assign bus2.snap = snap;  assign bus2.sel = sel;  assign bus2.rd_shadow = rd_shadow;

   aux_perf_counter_bank #(.NumCh(8), .CntBit(32), .SelBit(5), .Saturate(0)) dut_wrap32 (
      .clk (clk), .rst_n (rst_n), .bus (bus0));
   aux_perf_counter_bank #(.NumCh(8), .CntBit(8), .SelBit(5), .Saturate(0)) dut_wrap8 (
      .clk (clk), .rst_n (rst_n), .bus (bus1));
   aux_perf_counter_bank #(.NumCh(8), .CntBit(8), .SelBit(5), .Saturate(1)) dut_sat8 (
      .clk (clk), .rst_n (rst_n), .bus (bus2));

   logic [31:0] rd_obs  [3];
   logic [7:0]  ovf_obs [3];
   logic        sv_obs  [3];

   assign rd_obs[0] = bus0.rd_data;
   assign rd_obs[1] = {24'd0, bus1.rd_data};
   assign rd_obs[2] = {24'd0, bus2.rd_data};
   assign ovf_obs[0] = bus0.ovf;
   assign ovf_obs[1] = bus1.ovf;
   assign ovf_obs[2] = bus2.ovf;
   assign sv_obs[0] = bus0.snap_valid;
   assign sv_obs[1] = bus1.snap_valid;
   assign sv_obs[2] = bus2.snap_valid;

   // Reference model: counts as plain integers, limit = 2**width - 1.
   int              width [3] = '{32, 8, 8};
   bit              sat   [3] = '{1'b0, 1'b0, 1'b1};
   longint unsigned lv    [3][8];
   longint unsigned sh    [3][8];
   bit              ov    [3][8];
   bit              sv    [3];
   longint unsigned exp_rd [3];

   task automatic modelReset();
      for (int m = 0; m < 3; m++) begin
         for (int c = 0; c < 8; c++) begin
            lv[m][c] = 0;
            sh[m][c] = 0;
            ov[m][c] = 1'b0;
         end
         sv[m]     = 1'b0;
         exp_rd[m] = 0;
      end
   endtask

   task automatic modelEdge();
      for (int m = 0; m < 3; m++) begin
         longint unsigned limit = (64'd1 << width[m]) - 64'd1;
         if (sel < 5'd8) exp_rd[m] = rd_shadow ? sh[m][sel] : lv[m][sel];
         else            exp_rd[m] = 0;
         if (snap) for (int c = 0; c < 8; c++) sh[m][c] = lv[m][c];
         if (clr) begin
            for (int c = 0; c < 8; c++) begin
               lv[m][c] = 0;
               ov[m][c] = 1'b0;
            end
         end else if (en) begin
            for (int c = 0; c < 8; c++) begin
               if (evt[c]) begin
                  if (lv[m][c] == limit) begin
                     ov[m][c] = 1'b1;
                     lv[m][c] = sat[m] ? limit : 0;
                  end else begin
                     lv[m][c] = lv[m][c] + 1;
                  end
               end
            end
         end
         if (snap)     sv[m] = 1'b1;
         else if (clr) sv[m] = 1'b0;
      end
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      for (int m = 0; m < 3; m++) begin
         logic [7:0] ov_exp;
         for (int c = 0; c < 8; c++) ov_exp[c] = ov[m][c];
         checks++;
         assert (rd_obs[m] === 32'(exp_rd[m])) else begin
            errors++;
            $error("[TB] FAIL %s.rd_data inst%0d observed=0x%0h expected=0x%0h",
                   tag, m, rd_obs[m], 32'(exp_rd[m]));
         end
         checks++;
         assert (ovf_obs[m] === ov_exp) else begin
            errors++;
            $error("[TB] FAIL %s.ovf inst%0d observed=0x%0h expected=0x%0h",
                   tag, m, ovf_obs[m], ov_exp);
         end
         checks++;
         assert (sv_obs[m] === sv[m]) else begin
            errors++;
            $error("[TB] FAIL %s.snap_valid inst%0d observed=%0b expected=%0b",
                   tag, m, sv_obs[m], sv[m]);
         end
      end
   endtask

   // Inputs change 1 ns after an edge; outputs are compared 1 ns after the next edge.
   task automatic applyStimulus(input logic a_en, input logic [7:0] a_evt, input logic a_clr,
                                input logic a_snap, input logic [4:0] a_sel, input logic a_rs);
      en = a_en;  evt = a_evt;  clr = a_clr;
      snap = a_snap;  sel = a_sel;  rd_shadow = a_rs;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("step");
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0;  evt = 8'h00;  clr = 1'b0;  snap = 1'b0;  sel = 5'd0;  rd_shadow = 1'b0;
      modelReset();
      #5;
      checkOutput("reset");
      #20 rst_n = 1'b1;

      // Ten events on channel 0, then one idle edge to expose the count.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
      checkValue("ch0_after_10", rd_obs[0], 32'd10);
      for (int c = 1; c < 8; c++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 5'(c), 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
      checkValue("ovf_clean", {24'd0, ovf_obs[0]}, 32'd0);

      // Enable gating.
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0, 5'd1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 5'd1, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0);
      checkValue("ch1_gated", rd_obs[0], 32'd3);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
      checkValue("ch0_unchanged", rd_obs[0], 32'd10);

      // 257 events on channel 2: wrap vs saturate on the 8-bit variants.
      for (int i = 0; i < 257; i++) applyStimulus(1'b1, 8'h04, 1'b0, 1'b0, 5'd2, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0);
      checkValue("wrap8_ch2", rd_obs[1], 32'd1);
      checkValue("wrap8_ovf2", {31'd0, ovf_obs[1][2]}, 32'd1);
      checkValue("sat8_ch2", rd_obs[2], 32'd255);
      checkValue("sat8_ovf2", {31'd0, ovf_obs[2][2]}, 32'd1);
      checkValue("wrap32_ch2", rd_obs[0], 32'd257);

      // Snap and clr together while channel 0 is still counting.
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, 5'd0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1);
      checkValue("shadow0_snapclr", rd_obs[0], 32'd20);
      checkValue("snapclr_ovf", {24'd0, ovf_obs[1]}, 32'd0);
      checkValue("snapclr_valid", {31'd0, sv_obs[0]}, 32'd1);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
      checkValue("live0_snapclr", rd_obs[0], 32'd0);

      // Out-of-range select, then select-change latency.
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 5'd31, 1'b0);
      checkValue("sel31", rd_obs[0], 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
      sel = 5'd1;
      #2;
      checkValue("sel_not_yet", rd_obs[0], 32'd1);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0);
      checkValue("sel_one_cycle", rd_obs[0], 32'd3);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] r_sel;
         r_sel = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
         applyStimulus(($urandom_range(0, 7) != 0), 8'($urandom), ($urandom_range(0, 40) == 0),
                       ($urandom_range(0, 15) == 0), r_sel, 1'($urandom));
      end

      // Asynchronous reset mid-count: live 7, shadow 5.
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
      checkValue("pre_reset_live", rd_obs[0], 32'd7);
      #2 rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset");
      #2 rst_n = 1'b1;
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1);
      checkValue("post_reset_shadow", rd_obs[0], 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aux_perf_counter_bank.md
Name: aux_perf_counter_bank

Overview:
- Parametrised performance-counter bank that replaces the discrete per-event 32-bit counters in the top level: cycle, jump, branch, branched, bubble, load-use and future events.
- Counts events per channel under the core enable, and supports a synchronous clear, a coherent snapshot of all channels, optional saturation, and sticky overflow flags.
- Provides a registered readout mux that feeds the 7-segment display data mux.
- Sits in the core clock domain, between the core's status outputs and the display path.

Parameters:
- NumCh, 8, number of counter channels (1..32).
- CntBit, 32, width of each counter in bits (8..32).
- SelBit, 5, width of the readout select; NumCh must be at most 2**SelBit.
- Saturate, 0, 0 = counters wrap at 2**CntBit, 1 = counters hold at all-ones.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global count enable (core_en); when 0, no channel counts.
- evt  in  NumCh  per-channel event strobes, sampled each cycle.
- clr  in  1  synchronous clear of all counters and overflow flags.
- snap  in  1  one-cycle strobe: copy all live counters into shadow registers.
- sel  in  SelBit  readout channel index.
- rd_shadow  in  1  readout source: 0 = live counter, 1 = shadow register.
- rd_data  out  CntBit  registered readout value.
- ovf  out  NumCh  sticky per-channel overflow flags.
- snap_valid  out  1  set by the first snap, cleared by clr.

Behaviour:
- Reset (rst_n = 0, asynchronous): all live counters, shadows, ovf, rd_data and snap_valid go to 0 immediately and stay 0 while reset is held.
- Increment: channel i is incremented when en && evt[i] is sampled high at the clock edge.
  - Exactly +1 per cycle; there is no multi-count.
  - Several channels may increment in the same cycle, independently of each other.
- Wrap mode (Saturate = 0): a counter at all-ones that increments becomes 0, and ovf[i] is set.
- Saturate mode (Saturate = 1): a counter at all-ones that increments stays at all-ones, and ovf[i] is set.
- ovf[i] is sticky: only clr or reset clears it.
- clr, sampled high:
  - next cycle: every live counter = 0, every ovf = 0, snap_valid = 0;
  - clr has priority over any increment in the same cycle;
  - shadow registers are NOT cleared by clr.
- snap, sampled high: shadow[i] takes the live counter value from before this edge's update, i.e. the value visible on the live readout in the previous cycle; snap_valid is set to 1.
- snap and clr in the same cycle: the shadows capture the pre-clear values, the live counters clear, and snap_valid ends at 1 (snap wins for the flag).
- en = 0: counters freeze; clr, snap and readout still operate.
- Readout:
  - rd_data at edge k+1 reflects sel and rd_shadow sampled at edge k, using the counter/shadow state before edge k's update: one-cycle latency.
  - sel >= NumCh gives rd_data = 0.
- Width rules: counters are unsigned; rd_data is CntBit wide; the top level zero-extends it to 32 bits for display when CntBit < 32.
- There is no state machine beyond the per-channel registers; all behaviour is as stated above.

Decomposition:
- Auxiliary.vh:
  - channel index constants PERF_CH_CYC = 0, PERF_CH_JMP = 1, PERF_CH_BCH = 2, PERF_CH_BED = 3, PERF_CH_BUB = 4, PERF_CH_LU = 5;
  - a PERF_NUM_CH define;
  - the display-mux codes that select the bank.
- Sub-module aux_perf_counter_channel holds one live counter, its shadow and its ovf flag, with the wrap/saturate logic, parametrised by CntBit and Saturate.
- The bank instantiates NumCh of these in a generate loop and adds the readout mux register and snap_valid.

Test Plan:
- Reset, then en = 1 and evt = 8'h01 for 10 cycles, sel = 0, rd_shadow = 0 -> rd_data = 10 one cycle after the last event; all other channels read 0; ovf = 0.
- en = 0 with evt = 8'hFF for 5 cycles, then en = 1 and evt = 8'h02 for 3 cycles -> channel 1 reads 3 and all other channels are unchanged.
- CntBit = 8, Saturate = 0, channel 2 counts 257 events -> counter = 1, ovf[2] = 1; repeat with Saturate = 1 -> counter = 255, ovf[2] = 1.
- Channel 0 = 20, then snap and clr in the same cycle while evt[0] = 1 -> shadow[0] = 20, live[0] = 0, ovf = 0, snap_valid = 1; rd_shadow = 1 then reads 20.
- sel = 31 with NumCh = 8 -> rd_data = 0; change sel from 0 to 1 -> rd_data changes exactly one cycle later.
- Assert rst_n = 0 mid-count (channel 0 = 7, shadow = 5) -> rd_data, counters, shadows, ovf and snap_valid are all 0 before the next clock edge.
